uart_tx: RTL and testbench

//  Serial UART transmitter: the upstream partner of UART_RX and the source of its RX_in line.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divisor helper.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the last count. The counter is held at 0 whenever en is low,
// so every frame starts on a full bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int FREQUENCY = 10,
  parameter int BAUDRATE  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUDRATE);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  generate
    if (BAUDRATE < 1 || CLKS_PER_BIT < 1 || (FREQUENCY % BAUDRATE) != 0) begin : g_bad_rate
      $error("uart_baud_gen: FREQUENCY/BAUDRATE must be an integer >= 1");
    end
  endgenerate

  logic [CW-1:0] count;

  assign bit_tick = en && (count == CW'(CLKS_PER_BIT - 1));

  // Free-running bit-period counter, restarted when disabled or on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WORD_LENGHT data bits LSB first, optional even
// parity bit, one stop bit. Idle line is high. All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to insert the even parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 10,
  parameter int BAUDRATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGHT-1:0] TX_data,
  input  logic                   send,
  output logic                   TX_out,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(WORD_LENGHT);

  generate
    if (WORD_LENGHT < 5 || WORD_LENGHT > 16) begin : g_bad_width
      $error("uart_tx: WORD_LENGHT must be within 5..16");
    end
  endgenerate

  uart_state_t            state_q, state_n;
  logic [WORD_LENGHT-1:0] shift_q, shift_n;
  logic [IW-1:0]          idx_q, idx_n;
  logic                   busy_n, done_n, tx_n;
  logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_n;
`endif

  uart_baud_gen #(
    .FREQUENCY(FREQUENCY),
    .BAUDRATE (BAUDRATE)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != IDLE),
    .bit_tick(bit_tick)
  );

  // Next-state, datapath and registered-output values; the line value is
  // derived from the next state so TX_out tracks the state without lag.
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (send) begin
          shift_n = TX_data;
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = START;
`ifdef UART_TX_PARITY_EN
          parity_n = ^TX_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == IW'(WORD_LENGHT - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n   = idx_q + IW'(1);
            shift_n = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase

    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  // State, shift register, bit index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      TX_out  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      busy    <= busy_n;
      done    <= done_n;
      TX_out  <= tx_n;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: hand-written frame sequences, a vector table and
// randomized words, all compared against a cycle-level line model derived
// from the frame format, plus a mid-bit sampling decoder as a loopback check.
module tb_uart_tx;

  localparam int W    = 8;
  localparam int FREQ = 10;
  localparam int BAUD = 1;
  localparam int CPB  = FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         send = 1'b0;
  logic [W-1:0] TX_data = '0;
  logic         TX_out, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] word;
    logic         exp_parity;
    bit           mid_pulse;
    logic [W-1:0] mid_word;
  } vec_t;

  uart_tx #(
    .WORD_LENGHT(W),
    .FREQUENCY  (FREQ),
    .BAUDRATE   (BAUD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .TX_data(TX_data),
    .send   (send),
    .TX_out (TX_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Line level k cycles after acceptance, straight from the frame layout.
  function automatic logic expected_line(input logic [W-1:0] word, input logic par, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return word[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == W + 1) return par;
`endif
    return 1'b1;
  endfunction

  task automatic idleCheck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " idle TX_out"}, TX_out, 1);
      checkOutput({tag, " idle busy"}, busy, 0);
      checkOutput({tag, " idle done"}, done, 0);
      tick();
    end
  endtask

  // Sends one word and checks the whole frame cycle by cycle; ends in the
  // done cycle. keep_send leaves send high for a back-to-back frame.
  task automatic applyStimulus(input logic [W-1:0] word, input logic par, input bit keep_send,
                               input bit mid_pulse, input logic [W-1:0] mid_word, input string tag);
    logic [FRAME-1:0] captured;
    logic [W-1:0]     got;
    TX_data = word;
    send    = 1'b1;
    tick();
    if (!keep_send) send = 1'b0;
    TX_data = ~word;
    for (int k = 0; k < FRAME; k++) begin
      if (mid_pulse && k == 35) begin
        TX_data = mid_word;
        send    = 1'b1;
      end
      if (mid_pulse && k == 36) send = 1'b0;
      captured[k] = TX_out;
      checkOutput({tag, " line"}, TX_out, expected_line(word, par, k));
      checkOutput({tag, " busy"}, busy, 1);
      checkOutput({tag, " done early"}, done, 0);
      tick();
    end
    checkOutput({tag, " done pulse"}, done, 1);
    checkOutput({tag, " busy end"}, busy, 0);
    checkOutput({tag, " line end"}, TX_out, 1);
    for (int i = 0; i < W; i++) got[i] = captured[(i + 1) * CPB + CPB / 2];
    checkOutput({tag, " loopback word"}, got, word);
  endtask

  initial begin
    vec_t         table_v[6];
    int           seq[NBITS];
    logic [W-1:0] w;
    bit           keep;

    table_v[0] = '{word: 8'h03, exp_parity: 1'b0, mid_pulse: 1'b0, mid_word: 8'h00};
    table_v[1] = '{word: 8'hFF, exp_parity: 1'b0, mid_pulse: 1'b0, mid_word: 8'h00};
    table_v[2] = '{word: 8'h00, exp_parity: 1'b0, mid_pulse: 1'b0, mid_word: 8'h00};
    table_v[3] = '{word: 8'h80, exp_parity: 1'b1, mid_pulse: 1'b0, mid_word: 8'h00};
    table_v[4] = '{word: 8'hA5, exp_parity: 1'b0, mid_pulse: 1'b1, mid_word: 8'h5A};
    table_v[5] = '{word: 8'h01, exp_parity: 1'b1, mid_pulse: 1'b1, mid_word: 8'hFE};

`ifdef UART_TX_PARITY_EN
    seq = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1};
`else
    seq = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
`endif

    // Reset and quiet idle line.
    rst = 1'b1;
    #2;
    checkOutput("reset TX_out", TX_out, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    tick();
    tick();
    rst = 1'b0;
    idleCheck(50, "post-reset");

    // Hand-checked frame for 8'h64.
    $display("[TB] frame 8'h64");
    TX_data = 8'h64;
    send    = 1'b1;
    tick();
    send    = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        checkOutput("h64 bit", TX_out, seq[b]);
        checkOutput("h64 busy", busy, 1);
        checkOutput("h64 done early", done, 0);
        tick();
      end
    end
    checkOutput("h64 done", done, 1);
    checkOutput("h64 busy end", busy, 0);
    tick();
    checkOutput("h64 done single", done, 0);
    idleCheck(3, "h64");

    // Vector table, including ignored mid-frame requests.
    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(table_v[i].word, table_v[i].exp_parity, 1'b0,
                    table_v[i].mid_pulse, table_v[i].mid_word, "table");
      tick();
      idleCheck(3, "table");
    end

    // Back-to-back frames with send held high.
    $display("[TB] back-to-back");
    applyStimulus(8'h64, 1'b1, 1'b1, 1'b0, 8'h00, "b2b first");
    applyStimulus(8'h9B, 1'b1, 1'b1, 1'b0, 8'h00, "b2b second");
    applyStimulus(8'h9B, 1'b1, 1'b0, 1'b0, 8'h00, "b2b repeat");
    tick();
    idleCheck(5, "b2b");

    // Randomized words, random chaining and gaps.
    $display("[TB] random words");
    for (int i = 0; i < 15; i++) begin
      w    = W'($urandom);
      keep = (i != 14) && ($urandom_range(0, 1) == 1);
      applyStimulus(w, ^w, keep, 1'b0, 8'h00, "random");
      if (!keep) begin
        tick();
        idleCheck($urandom_range(1, 5), "random");
      end
    end

    // Reset in the middle of the data bits.
    $display("[TB] reset mid-frame");
    TX_data = 8'h00;
    send    = 1'b1;
    tick();
    send    = 1'b0;
    repeat (45) tick();
    checkOutput("midrst data low", TX_out, 0);
    checkOutput("midrst busy before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst TX_out async", TX_out, 1);
    checkOutput("midrst busy async", busy, 0);
    checkOutput("midrst done async", done, 0);
    tick();
    tick();
    rst = 1'b0;
    idleCheck(20, "midrst");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, "after reset");
    tick();
    idleCheck(3, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
